// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two requesters,
// registering operands and result and returning a tagged, back-pressurable response.
module alu_req_arbiter #(
  parameter int N      = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [N-1:0]      req0_a,
  input  logic [N-1:0]      req0_b,
  input  logic [CTRL_W-1:0] req0_op,
  input  logic              req0_uns,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [N-1:0]      req1_a,
  input  logic [N-1:0]      req1_b,
  input  logic [CTRL_W-1:0] req1_op,
  input  logic              req1_uns,
  output logic [N-1:0]      alu_rs1,
  output logic [N-1:0]      alu_rs2,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              alu_unsigned,
  input  logic [N-1:0]      alu_res,
  input  logic              alu_zf,
  input  logic              alu_neg,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [N-1:0]      resp_res,
  output logic              resp_zf,
  output logic              resp_neg,
  output logic              resp_err,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t state, state_nxt;
  logic   prio1;     // 1: req1 wins the next contention
  logic   id_p0;     // requester owning the operation in the operand registers
  logic   can_arb;
  logic   grant0, grant1;

  function automatic logic legal_op(input logic [CTRL_W-1:0] op);
    return (op < CTRL_W'(9)) || (op == CTRL_W'(10)) || (op == CTRL_W'(12));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    can_arb   = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE:    can_arb = 1'b1;
      EXEC:    state_nxt = HOLD;
      HOLD: begin
        can_arb = resp_ready;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (can_arb) begin
      grant0 = req0_valid & (~req1_valid | ~prio1);
      grant1 = req1_valid & (~req0_valid |  prio1);
      if (grant0 | grant1) state_nxt = EXEC;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // stage p0: operand capture on handshake; stage p1: result capture in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prio1        <= 1'b0;
      id_p0        <= 1'b0;
      alu_rs1      <= '0;
      alu_rs2      <= '0;
      alu_ctrl     <= '0;
      alu_unsigned <= 1'b0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_res     <= '0;
      resp_zf      <= 1'b0;
      resp_neg     <= 1'b0;
      resp_err     <= 1'b0;
      ops_done     <= '0;
    end else begin
      state <= state_nxt;
      if (grant0 | grant1) begin
        alu_rs1      <= grant1 ? req1_a   : req0_a;
        alu_rs2      <= grant1 ? req1_b   : req0_b;
        alu_ctrl     <= grant1 ? req1_op  : req0_op;
        alu_unsigned <= grant1 ? req1_uns : req0_uns;
        id_p0        <= grant1;
        prio1        <= grant0;
      end
      if (state == EXEC) begin
        resp_valid <= 1'b1;
        resp_id    <= id_p0;
        resp_res   <= alu_res;
        resp_zf    <= alu_zf;
        resp_neg   <= alu_neg;
        resp_err   <= ~legal_op(alu_ctrl);
      end else if ((state == HOLD) && resp_ready) begin
        resp_valid <= 1'b0;
        ops_done   <= sat_inc(ops_done);
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level reference model.
module tb_alu_req_arbiter;

  localparam int N      = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 8;

  logic              clk, rst_n;
  logic              req0_valid, req0_ready, req0_uns;
  logic [N-1:0]      req0_a, req0_b;
  logic [CTRL_W-1:0] req0_op;
  logic              req1_valid, req1_ready, req1_uns;
  logic [N-1:0]      req1_a, req1_b;
  logic [CTRL_W-1:0] req1_op;
  logic [N-1:0]      alu_rs1, alu_rs2, alu_res;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              alu_unsigned, alu_zf, alu_neg;
  logic              resp_valid, resp_ready, resp_id, resp_zf, resp_neg, resp_err;
  logic [N-1:0]      resp_res;
  logic [CNT_W-1:0]  ops_done;

  int total = 0;
  int bad   = 0;

  alu_req_arbiter #(.N(N), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_uns(req0_uns),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_uns(req1_uns),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl), .alu_unsigned(alu_unsigned),
    .alu_res(alu_res), .alu_zf(alu_zf), .alu_neg(alu_neg),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_res(resp_res),
    .resp_zf(resp_zf), .resp_neg(resp_neg), .resp_err(resp_err), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: illegal codes give 0
  function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [CTRL_W-1:0] op, input logic uns);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      4'd6:    return a - b;
      4'd7:    return uns ? N'(a < b) : N'($signed(a) < $signed(b));
      4'd8:    return N'($signed(a) >>> b[4:0]);
      4'd10:   return ~(a | b);
      4'd12:   return ~(a & b);
      default: return '0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_rs1, alu_rs2, alu_ctrl, alu_unsigned);
  assign alu_zf  = (alu_res == '0);
  assign alu_neg = alu_res[N-1];

  typedef struct packed {
    logic         id;
    logic [N-1:0] res;
    logic         zf;
    logic         neg;
    logic         err;
  } rsp_t;

  // Reference model state: at most one op in flight, at most one response shown
  logic m_inflight, m_shown, m_last;
  rsp_t m_fly, m_resp;
  int   m_cnt;
  logic g0, g1;

  function automatic rsp_t expect_rsp(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic [CTRL_W-1:0] op, input logic uns);
    rsp_t r;
    r.id  = id;
    r.res = alu_f(a, b, op, uns);
    r.zf  = (r.res == '0);
    r.neg = r.res[N-1];
    r.err = !(int'(op) inside {0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12});
    return r;
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0;
    m_shown    = 1'b0;
    m_last     = 1'b1;
    m_cnt      = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare one cycle against the model, then advance both across the clock edge
  task automatic tick();
    logic can, e0, e1;
    int   sat;
    #2;
    can = !m_inflight && (!m_shown || resp_ready);
    e0  = can && req0_valid && (!req1_valid || m_last);
    e1  = can && req1_valid && (!req0_valid || !m_last);
    sat = (m_cnt > 255) ? 255 : m_cnt;
    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    chk("resp_valid", 64'(resp_valid), 64'(m_shown));
    chk("ops_done", 64'(ops_done), 64'(sat));
    if (m_shown) chk("resp_fields", 64'({resp_id, resp_res, resp_zf, resp_neg, resp_err}), 64'(m_resp));
    if (m_shown && resp_ready) begin
      m_shown = 1'b0;
      m_cnt++;
    end
    if (m_inflight) begin
      m_shown    = 1'b1;
      m_resp     = m_fly;
      m_inflight = 1'b0;
    end
    if (e0 || e1) begin
      m_inflight = 1'b1;
      m_fly      = e1 ? expect_rsp(1'b1, req1_a, req1_b, req1_op, req1_uns)
                      : expect_rsp(1'b0, req0_a, req0_b, req0_op, req0_uns);
      m_last     = e1;
    end
    g0 = e0;
    g1 = e1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_ops_done", 64'(ops_done), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_uns = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_uns = 1'b0;
    g0 = 1'b0; g1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_operands", 64'({alu_rs1, alu_ctrl, alu_unsigned}), 64'(0));
    chk("reset_rs2", 64'(alu_rs2), 64'(0));
    chk("reset_resp", 64'({resp_valid, resp_id, resp_res, resp_zf, resp_neg, resp_err}), 64'(0));
    chk("reset_ops_done", 64'(ops_done), 64'(0));
    rst_n = 1'b1;

    // single ADD from req0
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'b0010; resp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("add_resp", 64'({resp_valid, resp_id, resp_zf, resp_neg, resp_err}), 64'(5'b10000));
    chk("add_res", 64'(resp_res), 64'(12));
    tick();
    chk("add_ops_done", 64'(ops_done), 64'(1));

    // continuous contention from a fresh reset
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd3;    req0_b = 32'd5;    req0_op = 4'b0110;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h3C;   req1_op = 4'b0000;
    tick();
    chk("contend_first_req0", 64'(g0), 64'(1));
    tick();
    chk("sub_res", 64'({resp_res, resp_neg, resp_id}), 64'({32'hFFFF_FFFE, 1'b1, 1'b0}));
    tick();
    chk("contend_second_req1", 64'(g1), 64'(1));
    tick();
    chk("and_res", 64'({resp_res, resp_id}), 64'({32'h30, 1'b1}));
    repeat (6) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    // back-pressure with req1 waiting
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0010; resp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hAA; req1_b = 32'h0F; req1_op = 4'b0011;
    tick();
    repeat (3) tick();
    resp_ready = 1'b1;
    tick();
    chk("bp_release_grant", 64'(g1), 64'(1));
    req1_valid = 1'b0;
    repeat (3) tick();

    // illegal op from req1
    req1_valid = 1'b1; req1_a = 32'h1234; req1_b = 32'h5678; req1_op = 4'b1111;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("illegal_resp", 64'({resp_valid, resp_res, resp_zf, resp_err, resp_id}), 64'({1'b1, 32'h0, 3'b111}));
    tick();

    // reset while the operation is in EXEC
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 4'b0010;
    tick();
    req1_valid = 1'b0;
    do_reset();
    repeat (3) tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    chk("post_rst_req0_wins", 64'(g0), 64'(1));
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) tick();
    // reset while a response is held
    do_reset();
    resp_ready = 1'b1;
    repeat (2) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || g0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_a = $urandom; req0_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
        req0_op = 4'($urandom_range(0, 15)); req0_uns = 1'($urandom_range(0, 1));
      end
      if (!req1_valid || g1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_a = $urandom; req1_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
        req1_op = 4'($urandom_range(0, 15)); req1_uns = 1'($urandom_range(0, 1));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    repeat (4) tick();

    // counter saturation
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 4'b0010; resp_ready = 1'b1;
    repeat (2 * 260 + 2) tick();
    chk("ops_done_saturated", 64'(ops_done), 64'(8'hFF));
    req0_valid = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
